// File: rtl/adc_input_capture_ctrl.sv
// ADC input capture sequencer: arms on start, optionally waits for a trigger,
// then streams exactly dsize samples (ADC or test ramp) out over AXI4-Stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for an accepted start (dsize != 0)
// S_ARM     | start latched; waiting for trigger (or straight through)
// S_CAPTURE | loading strobed samples into the output register
// S_DRAIN   | last beat loaded; waiting for its handshake
// S_DONE    | one cycle; sets the packet-complete flag
module adc_input_capture_ctrl #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic              abort,
    input  logic              cr_test,
    input  logic              trig_en,
    input  logic              trig,
    input  logic [CNT_W-1:0]  dsize,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    output logic              M_AXIS_TLAST,
    input  logic              M_AXIS_TREADY,
    output logic              sr_pc,
    input  logic              sr_pc_clr,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [DATA_W-1:0] ramp_q;
    logic [DATA_W-1:0] tdata_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic              pc_q;
    logic              ovf_q;
    logic              test_q;
    logic              trig_en_q;

    logic              out_free;
    logic              handshake;
    logic              last_load;
    logic [DATA_W-1:0] sample;

    // The output register can take a new sample when empty or emptying this cycle.
    assign out_free  = !tvalid_q || M_AXIS_TREADY;
    assign handshake = tvalid_q && M_AXIS_TREADY;
    assign last_load = (remaining_q == CNT_W'(1));
    assign sample    = test_q ? ramp_q : adc_data;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            ramp_q      <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            pc_q        <= 1'b0;
            ovf_q       <= 1'b0;
            test_q      <= 1'b0;
            trig_en_q   <= 1'b0;
        end else if (abort && (state_q != S_IDLE)) begin
            state_q  <= S_IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort && (dsize != '0)) begin
                        remaining_q <= dsize;
                        test_q      <= cr_test;
                        trig_en_q   <= trig_en;
                        ramp_q      <= '0;
                        ovf_q       <= 1'b0;
                        state_q     <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!trig_en_q || trig) begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (adc_valid) begin
                        if (test_q) begin
                            ramp_q <= ramp_q + DATA_W'(1);
                        end
                        if (out_free) begin
                            tdata_q     <= sample;
                            tvalid_q    <= 1'b1;
                            tlast_q     <= last_load;
                            remaining_q <= remaining_q - CNT_W'(1);
                            if (last_load) begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end else if (handshake) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (handshake && tlast_q) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Completion takes priority over a simultaneous read-to-clear.
            if (state_q == S_DONE) begin
                pc_q <= 1'b1;
            end else if (sr_pc_clr) begin
                pc_q <= 1'b0;
            end
        end
    end

    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign sr_pc         = pc_q;
    assign overflow      = ovf_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_input_capture_ctrl.sv
// Bench for adc_input_capture_ctrl: directed scenarios plus randomized packets,
// all cycles scored against a packet-level behavioural model.
module tb_adc_input_capture_ctrl;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 32;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic              start, abort, cr_test, trig_en, trig;
    logic [CNT_W-1:0]  dsize;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic [DATA_W-1:0] M_AXIS_TDATA;
    logic              M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
    logic              sr_pc, sr_pc_clr, overflow, busy;

    always #5 ACLK = ~ACLK;

    adc_input_capture_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .abort(abort),
        .cr_test(cr_test), .trig_en(trig_en), .trig(trig), .dsize(dsize),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
        .sr_pc(sr_pc), .sr_pc_clr(sr_pc_clr), .overflow(overflow), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit mon_en = 0;

    // Behavioural model: a packet in flight, how many samples it still needs,
    // and what the single output slot holds.
    bit              m_active, m_arming, m_finish, m_test, m_trigen;
    bit              m_tv, m_tl, m_pc, m_ovf;
    int unsigned     m_need;
    logic [DATA_W-1:0] m_td, m_ramp;

    logic [DATA_W-1:0] beat_data[$];
    bit                beat_last[$];
    int                beat_cyc[$];
    int                pc_rise_cyc = -1;
    bit                pc_prev = 0;

    function automatic void model_advance();
        bit hs;
        bit done_now;
        logic [DATA_W-1:0] s;
        hs = m_tv && (M_AXIS_TREADY === 1'b1);
        done_now = 0;
        if (ARESETN !== 1'b1) begin
            m_active = 0; m_arming = 0; m_finish = 0; m_test = 0; m_trigen = 0;
            m_tv = 0; m_tl = 0; m_pc = 0; m_ovf = 0; m_need = 0; m_td = '0; m_ramp = '0;
        end else if (abort && m_active) begin
            m_active = 0; m_arming = 0; m_finish = 0; m_need = 0; m_tv = 0; m_tl = 0;
        end else begin
            if (!m_active) begin
                if (start && !abort && dsize != 0) begin
                    m_active = 1; m_arming = 1; m_need = dsize;
                    m_test = cr_test; m_trigen = trig_en; m_ramp = '0; m_ovf = 0;
                end
            end else if (m_arming) begin
                if (!m_trigen || trig) m_arming = 0;
            end else if (m_need > 0) begin
                if (adc_valid) begin
                    s = m_test ? m_ramp : adc_data;
                    if (m_test) m_ramp = m_ramp + 1'b1;
                    if (!m_tv || M_AXIS_TREADY) begin
                        m_tv = 1; m_td = s; m_tl = (m_need == 1); m_need = m_need - 1;
                    end else begin
                        m_ovf = 1;
                    end
                end else if (hs) begin
                    m_tv = 0; m_tl = 0;
                end
            end else if (m_finish) begin
                m_active = 0; m_finish = 0; done_now = 1;
            end else if (hs) begin
                m_tv = 0; m_tl = 0; m_finish = 1;
            end
            if (done_now) m_pc = 1;
            else if (sr_pc_clr) m_pc = 0;
        end
    endfunction

    // Scoreboard at the falling edge: compare, log handshakes, then advance the model.
    always @(negedge ACLK) begin
        cyc++;
        if (mon_en) begin
            vectors++;
            if (M_AXIS_TVALID !== m_tv) begin
                miscompares++;
                $display("FAIL tvalid cyc=%0d got=%b exp=%b", cyc, M_AXIS_TVALID, m_tv);
            end
            if (M_AXIS_TLAST !== m_tl) begin
                miscompares++;
                $display("FAIL tlast cyc=%0d got=%b exp=%b", cyc, M_AXIS_TLAST, m_tl);
            end
            if (M_AXIS_TDATA !== m_td) begin
                miscompares++;
                $display("FAIL tdata cyc=%0d got=%h exp=%h", cyc, M_AXIS_TDATA, m_td);
            end
            if (busy !== m_active) begin
                miscompares++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_active);
            end
            if (sr_pc !== m_pc) begin
                miscompares++;
                $display("FAIL sr_pc cyc=%0d got=%b exp=%b", cyc, sr_pc, m_pc);
            end
            if (overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
            end
        end
        if (M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY === 1'b1) begin
            beat_data.push_back(M_AXIS_TDATA);
            beat_last.push_back(M_AXIS_TLAST === 1'b1);
            beat_cyc.push_back(cyc);
        end
        if (sr_pc === 1'b1 && !pc_prev) pc_rise_cyc = cyc;
        pc_prev = (sr_pc === 1'b1);
        model_advance();
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; trig = 0; adc_valid = 0; sr_pc_clr = 0; M_AXIS_TREADY = 1;
    endtask

    task automatic clear_log();
        beat_data.delete(); beat_last.delete(); beat_cyc.delete(); pc_rise_cyc = -1;
    endtask

    task automatic clear_pc();
        sr_pc_clr = 1; tick(1); sr_pc_clr = 0;
    endtask

    task automatic pulse_start(int unsigned ds, bit test, bit ten);
        dsize = ds; cr_test = test; trig_en = ten; start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic wait_idle(int budget, output bit ok);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            adc_data = DATA_W'($urandom);
            tick(1);
            k++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        ARESETN = 0;
        start = 1'($urandom); abort = 0; cr_test = 1'($urandom); trig_en = 1'($urandom);
        trig = 1'($urandom); dsize = $urandom; adc_data = DATA_W'($urandom);
        adc_valid = 1'($urandom); M_AXIS_TREADY = 1'($urandom); sr_pc_clr = 0;
        tick(3);
        vectors++; if (M_AXIS_TVALID !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got=%b exp=0", M_AXIS_TVALID); end
        vectors++; if (M_AXIS_TLAST !== 1'b0) begin miscompares++; $display("FAIL reset_tlast got=%b exp=0", M_AXIS_TLAST); end
        vectors++; if (M_AXIS_TDATA !== '0) begin miscompares++; $display("FAIL reset_tdata got=%h exp=0", M_AXIS_TDATA); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (sr_pc !== 1'b0) begin miscompares++; $display("FAIL reset_sr_pc got=%b exp=0", sr_pc); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        idle_inputs();
        mon_en = 1;
        ARESETN = 1;
        tick(2);
    endtask

    task automatic test_ramp_no_stall();
        bit ok;
        clear_pc(); clear_log();
        adc_valid = 1; M_AXIS_TREADY = 1;
        pulse_start(4, 1, 0);
        wait_idle(30, ok);
        tick(1);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ramp_timeout busy=%b exp=0", busy); end
        vectors++;
        if (beat_data.size() != 4) begin
            miscompares++; $display("FAIL ramp_beats got=%0d exp=4", beat_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (beat_data[i] !== DATA_W'(i) || beat_last[i] != (i == 3)) begin
                    miscompares++;
                    $display("FAIL ramp_beat%0d got=%h/%b exp=%h/%b", i, beat_data[i], beat_last[i], i, (i == 3));
                end
            end
            vectors++; if (beat_cyc[3] - beat_cyc[0] != 3) begin miscompares++; $display("FAIL ramp_consecutive span=%0d exp=3", beat_cyc[3] - beat_cyc[0]); end
            vectors++; if (pc_rise_cyc - beat_cyc[3] != 2) begin miscompares++; $display("FAIL ramp_pc_delay got=%0d exp=2", pc_rise_cyc - beat_cyc[3]); end
        end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ramp_overflow got=%b exp=0", overflow); end
        vectors++; if (sr_pc !== 1'b1) begin miscompares++; $display("FAIL ramp_sr_pc got=%b exp=1", sr_pc); end
        idle_inputs();
    endtask

    task automatic test_trigger();
        bit ok;
        clear_pc(); clear_log();
        adc_valid = 0; trig = 0; M_AXIS_TREADY = 1;
        pulse_start(2, 0, 1);
        for (int i = 0; i < 10; i++) begin
            adc_valid = 1'(i % 2); adc_data = DATA_W'($urandom);
            tick(1);
            vectors++;
            if (M_AXIS_TVALID !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL trig_wait%0d tvalid=%b busy=%b exp tvalid=0 busy=1", i, M_AXIS_TVALID, busy);
            end
        end
        trig = 1; adc_valid = 1;
        tick(1);
        trig = 0;
        wait_idle(20, ok);
        tick(1);
        vectors++; if (!ok) begin miscompares++; $display("FAIL trig_timeout busy=%b exp=0", busy); end
        vectors++;
        if (beat_data.size() != 2 || beat_last[0] != 0 || beat_last[1] != 1) begin
            miscompares++; $display("FAIL trig_beats count=%0d exp=2 with last only on 2nd", beat_data.size());
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int n = 0;
        int k = 0;
        logic [DATA_W-1:0] held;
        clear_pc(); clear_log();
        adc_valid = 1; M_AXIS_TREADY = 1; adc_data = 16'hA0;
        dsize = 3; cr_test = 0; trig_en = 0; start = 1;
        tick(1);
        start = 0;
        while (M_AXIS_TVALID !== 1'b1 && k < 20) begin
            n++; adc_data = DATA_W'(16'hA0 + n); tick(1); k++;
        end
        vectors++; if (M_AXIS_TVALID !== 1'b1) begin miscompares++; $display("FAIL bp_first_beat tvalid=%b exp=1", M_AXIS_TVALID); end
        held = M_AXIS_TDATA;
        M_AXIS_TREADY = 0;
        for (int i = 0; i < 3; i++) begin
            n++; adc_data = DATA_W'(16'hA0 + n);
            tick(1);
            vectors++;
            if (M_AXIS_TDATA !== held || M_AXIS_TVALID !== 1'b1 || M_AXIS_TLAST !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d got=%h/%b/%b exp=%h/1/0", i, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, held);
            end
        end
        M_AXIS_TREADY = 1;
        k = 0;
        while (busy !== 1'b0 && k < 20) begin
            n++; adc_data = DATA_W'(16'hA0 + n); tick(1); k++;
        end
        tick(1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_timeout busy=%b exp=0", busy); end
        vectors++;
        if (beat_data.size() != 3) begin
            miscompares++; $display("FAIL bp_beats got=%0d exp=3", beat_data.size());
        end else begin
            vectors++;
            if (beat_data[0] !== held || beat_last[0] || beat_last[1] || !beat_last[2]) begin
                miscompares++;
                $display("FAIL bp_order first=%h exp=%h lasts=%b%b%b exp=001", beat_data[0], held, beat_last[0], beat_last[1], beat_last[2]);
            end
        end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL bp_overflow got=%b exp=1", overflow); end
        idle_inputs();
    endtask

    task automatic test_abort();
        bit ok;
        int k = 0;
        int nlast = 0;
        clear_pc(); clear_log();
        adc_valid = 1; M_AXIS_TREADY = 1;
        pulse_start(100, 0, 0);
        while (beat_data.size() < 10 && k < 50) begin
            adc_data = DATA_W'($urandom); tick(1); k++;
        end
        vectors++; if (beat_data.size() < 10) begin miscompares++; $display("FAIL abort_prefix beats=%0d exp>=10", beat_data.size()); end
        M_AXIS_TREADY = 0;
        tick(2);
        abort = 1;
        tick(1);
        abort = 0;
        vectors++;
        if (M_AXIS_TVALID !== 1'b0 || busy !== 1'b0 || sr_pc !== 1'b0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_state tvalid=%b busy=%b sr_pc=%b ovf=%b exp 0/0/0/1", M_AXIS_TVALID, busy, sr_pc, overflow);
        end
        M_AXIS_TREADY = 1;
        tick(2);
        clear_log();
        pulse_start(100, 0, 0);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL abort_ovf_clear got=%b exp=0", overflow); end
        wait_idle(300, ok);
        tick(1);
        vectors++; if (!ok) begin miscompares++; $display("FAIL abort_restart_timeout busy=%b exp=0", busy); end
        foreach (beat_last[i]) if (beat_last[i]) nlast++;
        vectors++;
        if (beat_data.size() != 100 || nlast != 1 || !beat_last[beat_last.size()-1]) begin
            miscompares++;
            $display("FAIL abort_restart_pkt beats=%0d lasts=%0d exp 100/1", beat_data.size(), nlast);
        end
        vectors++; if (sr_pc !== 1'b1) begin miscompares++; $display("FAIL abort_restart_pc got=%b exp=1", sr_pc); end
        idle_inputs();
    endtask

    task automatic test_clear_race();
        int k = 0;
        clear_pc(); clear_log();
        adc_valid = 1; M_AXIS_TREADY = 1;
        pulse_start(2, 0, 0);
        while (!(M_AXIS_TVALID === 1'b1 && M_AXIS_TLAST === 1'b1) && k < 20) begin
            tick(1); k++;
        end
        vectors++; if (M_AXIS_TLAST !== 1'b1) begin miscompares++; $display("FAIL race_last tlast=%b exp=1", M_AXIS_TLAST); end
        tick(1);
        sr_pc_clr = 1;
        tick(1);
        sr_pc_clr = 0;
        vectors++; if (sr_pc !== 1'b1) begin miscompares++; $display("FAIL race_set_wins got=%b exp=1", sr_pc); end
        sr_pc_clr = 1;
        tick(1);
        sr_pc_clr = 0;
        vectors++; if (sr_pc !== 1'b0) begin miscompares++; $display("FAIL race_clear got=%b exp=0", sr_pc); end
        idle_inputs();
    endtask

    task automatic test_edge_cases();
        bit ok;
        clear_log();
        adc_valid = 1;
        pulse_start(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (busy !== 1'b0 || M_AXIS_TVALID !== 1'b0) begin
                miscompares++; $display("FAIL zero_size%0d busy=%b tvalid=%b exp 0/0", i, busy, M_AXIS_TVALID);
            end
            tick(1);
        end
        pulse_start(1, 0, 0);
        wait_idle(20, ok);
        tick(1);
        vectors++; if (!ok) begin miscompares++; $display("FAIL one_timeout busy=%b exp=0", busy); end
        vectors++;
        if (beat_data.size() != 1 || !beat_last[0]) begin
            miscompares++; $display("FAIL one_beat beats=%0d exp=1 with tlast", beat_data.size());
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_packet();
        int k = 0;
        bit saw_last = 0;
        clear_log();
        adc_valid = 1; M_AXIS_TREADY = 1;
        pulse_start(50, 1, 0);
        while (beat_data.size() < 5 && k < 30) begin tick(1); k++; end
        ARESETN = 0;
        tick(1);
        vectors++;
        if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 || M_AXIS_TDATA !== '0 ||
            busy !== 1'b0 || sr_pc !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset tv=%b tl=%b td=%h busy=%b pc=%b ovf=%b exp all 0",
                     M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, busy, sr_pc, overflow);
        end
        ARESETN = 1;
        tick(3);
        foreach (beat_last[i]) if (beat_last[i]) saw_last = 1;
        vectors++; if (saw_last) begin miscompares++; $display("FAIL midreset_tlast got=1 exp=0"); end
        idle_inputs();
    endtask

    task automatic test_random_packets();
        int k;
        for (int p = 0; p < 40; p++) begin
            idle_inputs();
            pulse_start($urandom_range(1, 12), 1'($urandom), 1'($urandom));
            k = 0;
            while (busy === 1'b1 && k < 300) begin
                adc_valid = ($urandom % 10) < 7;
                adc_data = DATA_W'($urandom);
                M_AXIS_TREADY = ($urandom % 4) != 0;
                trig = ($urandom % 5) == 0;
                sr_pc_clr = ($urandom % 10) == 0;
                start = ($urandom % 16) == 0;
                abort = (($urandom % 64) == 0) && !sr_pc_clr && !start && !m_finish;
                tick(1);
                k++;
            end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rand_timeout pkt=%0d busy=%b exp=0", p, busy); end
            idle_inputs();
            tick(1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN = 0; dsize = '0; cr_test = 0; trig_en = 0; adc_data = '0;
        idle_inputs();
        test_reset();
        test_ramp_no_stall();
        test_trigger();
        test_backpressure();
        test_abort();
        test_clear_race();
        test_edge_cases();
        test_reset_mid_packet();
        test_random_packets();
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_input_capture_ctrl.md
Name: adc_input_capture_ctrl

Overview:
Capture sequencer for the ADC input path. On a start command from the register block it optionally waits for a trigger. It then moves exactly dsize samples from the ADC sample strobe (or an internal test ramp when cr_test=1) into an AXI4-Stream master, and marks the final beat with TLAST. On completion it sets the packet-complete flag that the register block reports as SR_PC.

Parameters:
DATA_W, 16, ADC sample / TDATA width in bits
CNT_W, 32, width of the dsize sample counter

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETN  in  1  reset; synchronous, active-low
start  in  1  one-cycle command pulse from the register write logic
abort  in  1  one-cycle pulse; cancels any capture in progress
cr_test  in  1  1 = emit test ramp instead of ADC data; latched at start
trig_en  in  1  1 = wait for trig after start; latched at start
trig  in  1  external trigger, already synchronous to ACLK, level-sampled
dsize  in  CNT_W  samples per packet; latched at start
adc_data  in  DATA_W  ADC sample
adc_valid  in  1  sample strobe; cannot be stalled
M_AXIS_TDATA  out  DATA_W  stream data
M_AXIS_TVALID  out  1  stream valid
M_AXIS_TLAST  out  1  last beat of packet
M_AXIS_TREADY  in  1  stream ready
sr_pc  out  1  packet-complete flag; sticky
sr_pc_clr  in  1  clear for sr_pc (read-to-clear strobe from register logic)
overflow  out  1  sticky: a sample was dropped because the output register was full
busy  out  1  state != IDLE

Behaviour:
- Reset (ARESETN=0 at a rising edge): state=IDLE; TVALID=0, TLAST=0, TDATA=0; sr_pc=0; overflow=0; busy=0; remaining=0; ramp=0.
- States: IDLE, ARM, CAPTURE, DRAIN, DONE.
- IDLE, start=1 with dsize!=0: latch dsize into remaining, latch cr_test and trig_en, clear ramp and overflow, go to ARM. start with dsize==0 is ignored and the state stays IDLE. start outside IDLE is ignored.
- ARM: if the latched trig_en=0, or trig=1, go to CAPTURE next cycle. Samples strobed during ARM are discarded and do not set overflow.
- CAPTURE, when adc_valid=1, the sample is:
  - cr_test=1: the ramp value, after which ramp increments (wraps at 2^DATA_W);
  - cr_test=0: adc_data.
- Output register in CAPTURE:
  - Free means TVALID=0, or TVALID=1 with TREADY=1 in the same cycle.
  - If free: load TDATA, set TVALID=1, set TLAST=(remaining==1), decrement remaining.
  - If not free: drop the sample, set overflow=1, leave remaining unchanged.
- Latency: the sample strobed in cycle n appears on TDATA/TVALID in cycle n+1.
- When remaining reaches 0 (the cycle the last beat is loaded), go to DRAIN. DRAIN holds until TVALID&&TREADY with TLAST=1, then goes to DONE. adc_valid in DRAIN/DONE is ignored and does not set overflow.
- A beat without a new load clears TVALID and TLAST on handshake. TDATA, TVALID and TLAST stay stable while TVALID=1 && TREADY=0.
- DONE: set sr_pc=1, go to IDLE (one cycle).
- sr_pc_clr=1 clears sr_pc. A set in DONE in the same cycle wins, so sr_pc stays 1.
- abort=1 in any non-IDLE state: next state IDLE, TVALID=0, TLAST=0, sr_pc unchanged, overflow held. abort in IDLE has no effect. abort wins over a simultaneous start.
- overflow is cleared only by reset or by the next accepted start.
- Reset mid-packet: same as the reset values above. No partial TLAST is emitted.
- remaining is unsigned CNT_W. dsize up to 2^CNT_W-1 is supported. No wrap occurs because the decrement happens only when remaining >= 1.

Test Plan:
- Ramp, no stall: cr_test=1, trig_en=0, dsize=4, adc_valid=1 continuous, TREADY=1, start → TDATA 0,1,2,3 on consecutive cycles, TLAST only on 3, sr_pc=1 two cycles after the last beat, overflow=0.
- Trigger: trig_en=1, dsize=2, start, adc_valid toggling for 10 cycles before trig=1 → no TVALID before trig; then exactly 2 beats, the second with TLAST.
- Backpressure: cr_test=0, dsize=3, adc_valid every cycle, adc_data=0xA0+n, TREADY held 0 after the first beat for 3 cycles → beat 1 held stable, following samples dropped, overflow=1, remaining packet still exactly 3 beats with TLAST on the 3rd.
- Abort: dsize=100, abort after 10 beats → TVALID=0 next cycle, busy=0, sr_pc=0; a new start then produces a full 100-beat packet and clears overflow.
- Clear race: sr_pc_clr=1 in the DONE cycle → sr_pc=1; sr_pc_clr one cycle later → sr_pc=0.
- Edge cases: start with dsize=0 → busy stays 0, no beats; dsize=1 → a single beat with TLAST=1.
